serial_tx_arbiter: RTL

- Shares one serial byte shifter (load/done handshake, 10-bit frame: start, 8 data, stop, 16 clk per bit) between N_REQ requesters.
- Arbitrates round-robin and latches the winner's byte.
- Sequences the shifter's load/done handshake, returns a one-cycle ack to the winner, and enforces an idle gap so the shifter re-arms between frames.

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/rr_picker.sv | 34 +++
 rtl/serial_tx_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and constants for the serial TX arbiter.
//   tx_state_t    : arbiter FSM states
//   FRAME_*       : shifter frame geometry (start + 8 data + stop, 16 clk/bit)
//   MAX_REQ/IDX_W : upper bound on requesters and width of a requester index
//   onehot()      : index -> one-hot vector sized for MAX_REQ
package serial_tx_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RELEASE, GAP} tx_state_t;

   localparam int FRAME_BITS   = 10;
   localparam int BIT_CLKS     = 16;
   localparam int FRAME_CYCLES = FRAME_BITS * BIT_CLKS;

   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick.
//   req_i    : request vector
//   rr_ptr_i : last granted index; scan starts at rr_ptr_i+1 (mod N_REQ)
//   valid_o  : any request present
//   winner_o : first requester found on the scan
module rr_picker
   import serial_tx_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] winner_o
);

   // Widened so any IDX_W index is in range regardless of N_REQ.
   logic [MAX_REQ-1:0] req_ext;
   logic [IDX_W-1:0]   idx;

   assign req_ext = MAX_REQ'(req_i);
   assign valid_o = |req_i;

   // Scan from farthest to nearest so the nearest set bit after rr_ptr wins.
   always_comb begin
      winner_o = '0;
      idx      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(rr_ptr_i) + k) % N_REQ);
         if (req_ext[idx]) winner_o = idx;
      end
   end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin share of one serial byte shifter among N_REQ
// requesters. Latches the winner's byte, holds tx_load until tx_done, pulses
// a one-cycle ack to the winner, then idles GAP_CYCLES so the shifter re-arms.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_i, req_byte_i : level requests and per-requester bytes (8 bits each)
//   ack_o, tx_err_o   : one-hot one-cycle completion / timeout pulses
//   grant_id_o, busy_o: current/last grantee, not-IDLE flag
//   tx_load_o, tx_byte_o, tx_done_i : shifter handshake
// Optional: define SERIAL_TX_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES cycles in LOAD without tx_done (reported on tx_err_o).
module serial_tx_arbiter
   import serial_tx_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [8*N_REQ-1:0] req_byte_i,
   output logic [N_REQ-1:0]   ack_o,
   output logic [N_REQ-1:0]   tx_err_o,
   output logic [IDX_W-1:0]   grant_id_o,
   output logic               busy_o,
   output logic               tx_load_o,
   output logic [7:0]         tx_byte_o,
   input  logic               tx_done_i
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   tx_state_t          state_q;
   logic [IDX_W-1:0]   rr_ptr_q, grant_id_q;
   logic [7:0]         tx_byte_q, gap_cnt_q, gap_cnt_d;
   logic               tx_load_q, busy_q;
   logic [N_REQ-1:0]   ack_q;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_id;
   logic [MAX_REQ-1:0][7:0] byte_arr;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (pick_vld),
      .winner_o (pick_id)
   );

   // Byte lanes padded to MAX_REQ so the grant index selects without width games.
   always_comb begin
      byte_arr = '0;
      for (int i = 0; i < N_REQ; i++) byte_arr[i] = req_byte_i[8*i +: 8];
   end

   assign gap_cnt_d = gap_cnt_q + 8'd1;

`ifdef SERIAL_TX_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]       to_cnt_q, to_cnt_d;
   logic [N_REQ-1:0] tx_err_q;
   assign to_cnt_d = to_cnt_q + 8'd1;
   assign tx_err_o = tx_err_q;
`else
   assign tx_err_o = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= IDX_W'(N_REQ - 1);
         grant_id_q <= '0;
         tx_byte_q  <= '0;
         tx_load_q  <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= '0;
         gap_cnt_q  <= '0;
`ifdef SERIAL_TX_TIMEOUT_EN
         to_cnt_q   <= '0;
         tx_err_q   <= '0;
`endif
      end else begin
         // Completion pulses last exactly one cycle (the RELEASE cycle).
         ack_q <= '0;
`ifdef SERIAL_TX_TIMEOUT_EN
         tx_err_q <= '0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  tx_byte_q  <= byte_arr[pick_id];
                  grant_id_q <= pick_id;
                  rr_ptr_q   <= pick_id;
                  tx_load_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= LOAD;
`ifdef SERIAL_TX_TIMEOUT_EN
                  to_cnt_q   <= '0;
`endif
               end
            end
            LOAD: begin
               // tx_done wins over a coincident timeout.
               if (tx_done_i) begin
                  tx_load_q <= 1'b0;
                  ack_q     <= N_REQ'(onehot(grant_id_q));
                  state_q   <= RELEASE;
               end
`ifdef SERIAL_TX_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  tx_load_q <= 1'b0;
                  tx_err_q  <= N_REQ'(onehot(grant_id_q));
                  state_q   <= RELEASE;
               end else begin
                  to_cnt_q  <= to_cnt_d;
               end
`endif
            end
            RELEASE: begin
               gap_cnt_q <= '0;
               state_q   <= GAP;
            end
            GAP: begin
               // Stale tx_done is deliberately not looked at here.
               if (gap_cnt_q == GAP_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack_o      = ack_q;
   assign grant_id_o = grant_id_q;
   assign busy_o     = busy_q;
   assign tx_load_o  = tx_load_q;
   assign tx_byte_o  = tx_byte_q;

endmodule
